// File: rtl/top_arbiter.sv
// top_arbiter
//
// Round-robin arbiter and sequencer in front of the shared `top` datapath.
// One requester at a time owns the datapath; the grant ends on a completion
// strobe, on withdrawal of the owner's request, or when the hold limit is
// reached. A forced end is flagged by a one-cycle timeout pulse. Every grant
// is followed by a one-cycle gap before the next arbitration.
//
// Parameters
//   N         number of requesters (N >= 2)
//   MAX_HOLD  maximum grant length in cycles (MAX_HOLD >= 1)
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset, highest priority
//   req      in   [N-1:0] request vector, bit i = requester i
//   done     in   completion strobe, only looked at while a grant is active
//   grant    out  [N-1:0] registered one-hot grant, zero when not busy
//   sel      out  index of the granted requester, holds its value when idle
//   busy     out  high exactly while a grant bit is high
//   timeout  out  one-cycle pulse in the gap after a forced end

module top_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N-1:0]                        req,
  input  logic                                done,
  output logic [N-1:0]                        grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] sel,
  output logic                                busy,
  output logic                                timeout
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  // Last hold count value before the grant is forcibly ended.
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [SW-1:0] SEL_LAST  = SW'(N - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] ptr;
  logic [HW-1:0] hold_cnt;

  logic [SW-1:0] pick;
  logic [N-1:0]  pick_onehot;
  logic [SW-1:0] ptr_next;
  logic          at_limit;
  logic          owner_req;
  logic          end_grant;
  logic          forced_end;

  // Round-robin search: first set bit of r at or above p, wrapping N-1 -> 0.
  // The request vector is rotated so that bit p lands at position 0, the
  // lowest set bit gives the offset, and the offset is added back modulo N.
  function automatic logic [SW-1:0] rr_pick(input logic [N-1:0] r,
                                            input logic [SW-1:0] p);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SW-1:0]  off;
    logic           found;
    logic [SW:0]    sum;
    dbl   = {r, r} >> p;
    rot   = dbl[N-1:0];
    off   = {SW{1'b0}};
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = SW'(k);
      end else begin
        found = found;
      end
    end
    sum = {1'b0, p} + {1'b0, off};
    if (sum >= (SW + 1)'(N)) begin
      sum = sum - (SW + 1)'(N);
    end else begin
      sum = sum;
    end
    return sum[SW-1:0];
  endfunction

  // Arbitration choice, exit decode and next pointer for the current cycle.
  always_comb begin
    pick        = rr_pick(req, ptr);
    pick_onehot = {{(N - 1){1'b0}}, 1'b1} << pick;
    at_limit    = (hold_cnt == HOLD_LAST);
    owner_req   = req[sel];
    end_grant   = 1'b0;
    forced_end  = 1'b0;
    if (state == ST_GRANT) begin
      end_grant  = done | ~owner_req | at_limit;
      // done or withdrawal take precedence over the hold limit
      forced_end = ~done & owner_req & at_limit;
    end else begin
      end_grant  = 1'b0;
      forced_end = 1'b0;
    end
    if (sel == SEL_LAST) begin
      ptr_next = {SW{1'b0}};
    end else begin
      ptr_next = sel + SW'(1);
    end
  end

  // Sequencer state, pointer, hold counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= {SW{1'b0}};
      hold_cnt <= {HW{1'b0}};
      grant    <= {N{1'b0}};
      sel      <= {SW{1'b0}};
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          timeout <= 1'b0;
          if (|req) begin
            state    <= ST_GRANT;
            grant    <= pick_onehot;
            sel      <= pick;
            busy     <= 1'b1;
            hold_cnt <= {HW{1'b0}};
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (end_grant) begin
            state   <= ST_GAP;
            grant   <= {N{1'b0}};
            busy    <= 1'b0;
            ptr     <= ptr_next;
            timeout <= forced_end;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
            timeout  <= 1'b0;
          end
        end
        ST_GAP: begin
          // requests seen here are ignored; arbitration resumes in IDLE
          state   <= ST_IDLE;
          timeout <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          grant    <= {N{1'b0}};
          busy     <= 1'b0;
          timeout  <= 1'b0;
          hold_cnt <= {HW{1'b0}};
        end
      endcase
    end
  end

  top_arbiter_checker #(
    .N  (N),
    .SW (SW)
  ) u_checker (
    .clk     (clk),
    .rst     (rst),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

endmodule

// top_arbiter_checker
//
// Output invariants of top_arbiter: grant is one-hot or zero, busy mirrors
// the grant vector, the granted bit matches sel, and timeout never overlaps
// an active grant.
//
// Ports
//   clk, rst                      clock and synchronous reset of the arbiter
//   grant, sel, busy, timeout     arbiter outputs under observation

module top_arbiter_checker #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic [N-1:0]  grant,
  input logic [SW-1:0] sel,
  input logic          busy,
  input logic          timeout
);

  // Output invariants sampled on every edge outside reset.
  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(grant));
      assert (busy == (|grant));
      assert (!(timeout && busy));
      assert (!busy || grant[sel]);
    end else begin
    end
  end

endmodule

// File: tb/tb_top_arbiter.sv
module tb_top_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_cmp;
  int n_bad;

  top_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       rst;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] r, input logic d, input logic rs,
                              input logic [3:0] g, input logic [1:0] s);
    vec_t v;
    v.req     = r;
    v.done    = d;
    v.rst     = rs;
    v.grant   = g;
    v.sel     = s;
    v.busy    = |g;
    v.timeout = 1'b0;
    return v;
  endfunction

  // Drive inputs away from the rising edge, let one edge pass, return at the
  // following falling edge where outputs are sampled.
  task automatic step(input logic [3:0] r, input logic d, input logic rs);
    req  = r;
    done = d;
    rst  = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string nm, input logic [3:0] eg, input logic [1:0] es,
                           input logic eb, input logic et);
    n_cmp++;
    if (grant !== eg || sel !== es || busy !== eb || timeout !== et) begin
      n_bad++;
      $display("FAIL %s @%0t: got grant=%b sel=%0d busy=%b timeout=%b, want grant=%b sel=%0d busy=%b timeout=%b",
               nm, $time, grant, sel, busy, timeout, eg, es, eb, et);
    end
  endtask

  // Reference model: who owns the datapath, how many cycles it has held it,
  // whether we are in the post-grant gap, and where the next search begins.
  int m_cur;
  int m_len;
  int m_ptr;
  int m_sel;
  bit m_cool;
  bit m_to;

  task automatic model_edge(input logic [3:0] r, input logic d, input logic rs);
    int ri;
    bit owner_wants;
    ri   = int'(r);
    m_to = 1'b0;
    if (rs) begin
      m_cur  = -1;
      m_len  = 0;
      m_ptr  = 0;
      m_sel  = 0;
      m_cool = 1'b0;
    end else if (m_cur >= 0) begin
      owner_wants = ((ri >> m_cur) & 1) != 0;
      if (d || !owner_wants || (m_len + 1 == MAX_HOLD)) begin
        m_to   = !d && owner_wants;
        m_ptr  = (m_cur + 1) % N;
        m_cur  = -1;
        m_cool = 1'b1;
      end else begin
        m_len++;
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (ri != 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_cur < 0 && ((ri >> idx) & 1) != 0) begin
          m_cur = idx;
          m_sel = idx;
          m_len = 0;
        end
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic [3:0] r;
    logic       d;
    logic       rs;
    logic [3:0] eg;
    n_cmp = 0;
    n_bad = 0;
    req   = 4'b0000;
    done  = 1'b0;
    rst   = 1'b1;
    @(negedge clk);

    // Single requester, pointer advance, round-robin order, withdrawal.
    tbl.push_back(mk(4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1));
    tbl.push_back(mk(4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1));
    tbl.push_back(mk(4'b0010, 1'b1, 1'b0, 4'b0000, 2'd1));
    tbl.push_back(mk(4'b0110, 1'b0, 1'b0, 4'b0000, 2'd1));
    tbl.push_back(mk(4'b0110, 1'b0, 1'b0, 4'b0100, 2'd2));
    tbl.push_back(mk(4'b0110, 1'b1, 1'b0, 4'b0000, 2'd2));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0010, 2'd1));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd1));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd1));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd2));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd2));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd3));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd3));
    tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0));
    tbl.push_back(mk(4'b0100, 1'b0, 1'b1, 4'b0000, 2'd0));
    tbl.push_back(mk(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2));
    tbl.push_back(mk(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2));
    tbl.push_back(mk(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2));
    tbl.push_back(mk(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2));
    tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2));
    tbl.push_back(mk(4'b1001, 1'b0, 1'b0, 4'b0000, 2'd2));
    tbl.push_back(mk(4'b1001, 1'b0, 1'b0, 4'b1000, 2'd3));
    tbl.push_back(mk(4'b1001, 1'b1, 1'b0, 4'b0000, 2'd3));

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].done, tbl[i].rst);
      check_out($sformatf("table[%0d]", i), tbl[i].grant, tbl[i].sel, tbl[i].busy, tbl[i].timeout);
    end

    // Hold timeout: sole requester, never done.
    step(4'b0000, 1'b0, 1'b1);
    check_out("hold_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(4'b0001, 1'b0, 1'b0);
      check_out($sformatf("hold_cycle%0d", i + 1), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step(4'b0001, 1'b0, 1'b0);
    check_out("hold_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b0);
    check_out("hold_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    check_out("hold_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // done coinciding with the hold limit is a normal end.
    for (int i = 1; i < MAX_HOLD; i++) begin
      step(4'b0001, 1'b0, 1'b0);
      check_out($sformatf("limit_cycle%0d", i + 1), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step(4'b0001, 1'b1, 1'b0);
    check_out("done_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset in the 5th grant cycle.
    step(4'b0100, 1'b0, 1'b0);
    check_out("rst_pre_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0100, 1'b0, 1'b0);
      check_out($sformatf("rst_grant%0d", i + 1), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    step(4'b0100, 1'b0, 1'b1);
    check_out("rst_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    check_out("rst_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Randomized traffic against the reference model.
    r = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        r = 4'($urandom_range(15));
      end
      d  = ($urandom_range(5) == 0);
      rs = (c == 0) || ($urandom_range(299) == 0);
      step(r, d, rs);
      model_edge(r, d, rs);
      eg = (m_cur >= 0) ? 4'(32'd1 << m_cur) : 4'b0000;
      check_out("random", eg, 2'(m_sel), m_cur >= 0, m_to);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
